mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the core's two memory clients (instruction fetch and the store/load buffer) and the single byte-wide RAM/IO port of the `cpu` top. It accepts word or sub-word requests, serializes them into byte accesses with the RAM's one-cycle read latency, arbitrates between the clients, stalls IO writes on a full UART buffer, and aborts speculative reads on a pipeline flush.

## Interface
Parameters:
- `IO_SEL`, 2'b11, value of `addr[17:16]` that marks an IO address

Ports:
- `clk_in`  in  1  clock
- `rst_in`  in  1  reset; one clock, synchronous, active-high
- `rdy_in`  in  1  0 = freeze all state
- `clear`  in  1  flush (`control_hazard`); aborts reads
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  32  fetch byte address
- `if_done`  out  1  one-cycle pulse, `if_data` valid
- `if_data`  out  32  fetched word, little-endian
- `lsb_req`  in  1  load/store request, held until `lsb_done`
- `lsb_wr`  in  1  1 = store
- `lsb_addr`  in  32  byte address
- `lsb_size`  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B (3 illegal, treated as 4 B)
- `lsb_wdata`  in  32  store data, byte i = bits [8i+7:8i]
- `lsb_done`  out  1  one-cycle pulse
- `lsb_rdata`  out  32  load data, zero-extended; unused upper bytes are 0
- `io_buffer_full`  in  1  UART buffer full
- `mem_din`  in  8  RAM read byte
- `mem_dout`  out  8  RAM write byte
- `mem_a`  out  32  RAM address
- `mem_wr`  out  1  1 = write

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR. Byte counter `cnt` runs 0..4. Address, size, and write data are latched on entry.
- IDLE:
  - `lsb_req` has priority over `if_req`. `lsb_wr` selects LS_WR or LS_RD.
  - Requests are ignored in any cycle where `if_done`/`lsb_done` is high (done-cycle guard) or `clear` is high.
- Byte i uses address `addr + i` with 32-bit wrap. N = 4 for IF and 1/2/4 for LSB per `lsb_size`.
- Reads: byte i is captured from `mem_din` into result bits [8i+7:8i]. After byte N-1 is captured, the matching done pulse is raised and the state returns to IDLE.
- Writes: byte i drives `mem_dout` = wdata byte i with `mem_wr`=1. After N bytes, `lsb_done` pulses and the state returns to IDLE.
- IO write stall: a store with `addr[17:16]==IO_SEL` issues the next byte only when `io_buffer_full` is 0 in the cycle its bus registers load. Otherwise the bus stays idle and `cnt` holds.
- `clear`:
  - In IF_RD or LS_RD: return to IDLE next cycle, no done pulse, bus idle.
  - In LS_WR: ignored, because stores are committed and must complete.
  - Any done pulse due in the next cycle is suppressed, except `lsb_done` of a store.
- `rdy_in`=0: no register changes. Outputs hold. Resuming continues the same sequence.
- Bus idle values: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `cnt`=0, `mem_a`=0, `mem_wr`=0, `mem_dout`=0, `if_done`=0, `lsb_done`=0, `if_data`=0, `lsb_rdata`=0.
- Reset mid-transaction abandons it immediately. A partially written store is not completed.
- Timing is counted from cycle 0, the IDLE cycle in which the request is accepted.
- Read, N bytes:
  - byte i address is on `mem_a` in cycle 1+i;
  - `mem_din` carries byte i in cycle 2+i;
  - done is high in cycle N+2, so a 4-byte read has latency 6.
- Write, N bytes:
  - byte i is on the bus in cycle 1+i;
  - done is high in cycle N+1, plus any IO stall cycles.
- The done cycle is spent in IDLE with the guard active. The earliest next acceptance is cycle N+3 for a read and N+2 for a write.
- Requesters must drop `*_req` in the cycle they see `*_done`.
- `if_data`/`lsb_rdata` hold their value until the next completion of the same client.

## Test plan
- IF read at 0x1000, RAM holds 13 00 50 00 -> `mem_a` shows 0x1000..0x1003 in cycles 1-4, `mem_wr`=0, `if_done` in cycle 6, `if_data`=0x00500013.
- LSB store halfword 0xBEEF to 0x20 -> cycle 1: `mem_a`=0x20, `mem_dout`=0xEF, `mem_wr`=1; cycle 2: `mem_a`=0x21, `mem_dout`=0xBE, `mem_wr`=1; `lsb_done` in cycle 3.
- Simultaneous `if_req`@0x0 and `lsb_req` load byte @0x100 (RAM=0x80) -> LSB served first, `lsb_rdata`=0x00000080 in cycle 3; IF accepted in cycle 4 and `if_done` in cycle 10.
- Store byte 0x41 to 0x30000 with `io_buffer_full`=1 for cycles 0-4 -> `mem_wr` stays 0 until the buffer frees, then one write of 0x41, then `lsb_done` next cycle.
- IF read with `clear` in cycle 3 -> state IDLE in cycle 4, no `if_done`, bus idle. Repeat during a 4-byte store -> all 4 bytes written and `lsb_done` asserted.
- `rst_in` in cycle 2 of a 4-byte store -> from the next cycle all outputs are 0 and no further bytes are written; `rdy_in`=0 for 3 cycles mid-read -> same data, done delayed by 3 cycles.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: client and RAM-side signals of the memory controller.
//   Fetch client: if_req/if_addr in, if_done/if_data out.
//   Load/store client: lsb_req/lsb_wr/lsb_addr/lsb_size/lsb_wdata in,
//     lsb_done/lsb_rdata out.
//   RAM/IO port: mem_din and io_buffer_full in, mem_dout/mem_a/mem_wr out.
// The slave modport is the controller's view; master is the environment's.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  if_req, if_addr, lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
           io_buffer_full, mem_din,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
           io_buffer_full, mem_din,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes fetch and load/store word/sub-word requests onto a
// byte-wide RAM/IO port with one-cycle read latency.
//   clk_in  - clock
//   rst_in  - synchronous active-high reset
//   rdy_in  - 0 freezes every register
//   clear   - pipeline flush; aborts reads, stores run to completion
//   bus     - mem_ctrl_if.slave (client handshakes + RAM port)
// The load/store client wins arbitration. IO stores (addr[17:16]==IO_SEL)
// hold off each byte while the UART buffer is full. All outputs are
// registered; the bus reads back as zero whenever no byte is issued.
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      clear,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state;
  logic [2:0]  cnt;     // reads: cycles spent in state; writes: bytes issued
  logic [2:0]  nbytes;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;    // partial read assembly, cleared on accept

  logic        guard_ok;
  logic [2:0]  lsb_n;
  logic [1:0]  cap_idx;
  logic [31:0] rd_result;
  logic [31:0] rd_next_a;
  logic [31:0] wr_a;
  logic [7:0]  wr_byte;
  logic        wr_stall;
  logic        acc_stall;

  // A done pulse on the outputs marks the completion cycle; no new request
  // may be taken then, nor during a flush.
  assign guard_ok  = !bus.if_done && !bus.lsb_done && !clear;
  // In a read state with cnt = c, mem_din carries byte c-1.
  assign cap_idx   = cnt[1:0] - 2'd1;
  assign rd_next_a = addr + {29'd0, cnt} + 32'd1;
  assign wr_a      = addr + {29'd0, cnt};
  assign wr_byte   = wdata[{cnt[1:0], 3'b000} +: 8];
  assign wr_stall  = (addr[17:16] == IO_SEL) && bus.io_buffer_full;
  assign acc_stall = (bus.lsb_addr[17:16] == IO_SEL) && bus.io_buffer_full;

  always_comb begin
    case (bus.lsb_size)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
    // Final word: earlier bytes from rbuf, last byte straight off mem_din.
    rd_result = rbuf;
    rd_result[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      nbytes        <= 3'd0;
      addr          <= 32'd0;
      wdata         <= 32'd0;
      rbuf          <= 32'd0;
      bus.mem_a     <= 32'd0;
      bus.mem_wr    <= 1'b0;
      bus.mem_dout  <= 8'd0;
      bus.if_done   <= 1'b0;
      bus.lsb_done  <= 1'b0;
      bus.if_data   <= 32'd0;
      bus.lsb_rdata <= 32'd0;
    end else if (rdy_in) begin
      bus.if_done  <= 1'b0;
      bus.lsb_done <= 1'b0;
      bus.mem_a    <= 32'd0;
      bus.mem_wr   <= 1'b0;
      bus.mem_dout <= 8'd0;
      case (state)
        IDLE: begin
          if (guard_ok && (bus.lsb_req || bus.if_req)) begin
            cnt  <= 3'd0;
            rbuf <= 32'd0;
            if (bus.lsb_req) begin
              addr   <= bus.lsb_addr;
              wdata  <= bus.lsb_wdata;
              nbytes <= lsb_n;
              if (bus.lsb_wr) begin
                state <= LS_WR;
                // Byte 0 goes out on entry unless the IO buffer is full.
                if (!acc_stall) begin
                  bus.mem_a    <= bus.lsb_addr;
                  bus.mem_dout <= bus.lsb_wdata[7:0];
                  bus.mem_wr   <= 1'b1;
                  cnt          <= 3'd1;
                end
              end else begin
                state     <= LS_RD;
                bus.mem_a <= bus.lsb_addr;
              end
            end else begin
              state     <= IF_RD;
              addr      <= bus.if_addr;
              nbytes    <= 3'd4;
              bus.mem_a <= bus.if_addr;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (clear) begin
            state <= IDLE;
          end else begin
            if (cnt != 3'd0) rbuf[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
            if (cnt == nbytes) begin
              state <= IDLE;
              if (state == IF_RD) begin
                bus.if_done <= 1'b1;
                bus.if_data <= rd_result;
              end else begin
                bus.lsb_done  <= 1'b1;
                bus.lsb_rdata <= rd_result;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt + 3'd1 < nbytes) bus.mem_a <= rd_next_a;
            end
          end
        end
        LS_WR: begin
          // Stores are already committed, so a flush has no effect here.
          if (cnt == nbytes) begin
            state        <= IDLE;
            bus.lsb_done <= 1'b1;
          end else if (!wr_stall) begin
            bus.mem_a    <= wr_a;
            bus.mem_dout <= wr_byte;
            bus.mem_wr   <= 1'b1;
            cnt          <= cnt + 3'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear;
  mem_ctrl_if bus();

  mem_ctrl #(.IO_SEL(2'b11)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM, 1 KiB aliased over the address space, one-cycle read latency.
  // Frozen together with the controller while rdy_in is low.
  logic [7:0] ram [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_a;
  logic [7:0] pre_d;
  always @(posedge clk_in) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (rdy_in) begin
      if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[9:0]];
    end
  end

  // Reference memory image maintained from the request stream alone.
  logic [7:0] shadow [0:1023];

  int vectors = 0, miscompares = 0;

  // Per-transaction observations.
  logic [31:0] tr_a [0:63];
  logic        tr_wr [0:63];
  logic [7:0]  tr_d [0:63];
  int          done_cyc;
  logic        obs_if, obs_lsb;
  logic [31:0] obs_data;

  // Per-transaction stimulus knobs (cycle numbers relative to acceptance).
  int frz_at, frz_len, full_from, full_to, clr_at, rst_at, cur_kind;

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic knobs_clear();
    frz_at = -100; frz_len = 0; full_from = 1; full_to = 0; clr_at = -1; rst_at = -1;
  endtask

  task automatic apply_knobs(input int c);
    rdy_in = !(c >= frz_at && c < frz_at + frz_len);
    bus.io_buffer_full = (c >= full_from && c <= full_to);
    clear = (c == clr_at);
    rst_in = (c == rst_at);
    if (c == rst_at || (c == clr_at && cur_kind != 2)) begin
      bus.if_req = 1'b0; bus.lsb_req = 1'b0;
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a[9:0]; pre_d = d; shadow[a[9:0]] = d;
    tick();
    pre_we = 1'b0;
  endtask

  // kind: 0 fetch, 1 load, 2 store. Called in a cycle where the controller
  // can accept; returns in the earliest cycle the next request may be taken.
  task automatic xact(input int kind, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input int limit);
    cur_kind = kind;
    done_cyc = -1; obs_if = 1'b0; obs_lsb = 1'b0; obs_data = 32'd0;
    for (int i = 0; i < 64; i++) begin tr_a[i] = 32'd0; tr_wr[i] = 1'b0; tr_d[i] = 8'd0; end
    if (kind == 0) begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end else begin
      bus.lsb_req = 1'b1; bus.lsb_wr = (kind == 2); bus.lsb_addr = a;
      bus.lsb_size = sz; bus.lsb_wdata = wd;
    end
    apply_knobs(0);
    for (int c = 1; c <= limit; c++) begin
      tick();
      apply_knobs(c);
      tr_a[c] = bus.mem_a; tr_wr[c] = bus.mem_wr; tr_d[c] = bus.mem_dout;
      if (bus.if_done || bus.lsb_done) begin
        done_cyc = c; obs_if = bus.if_done; obs_lsb = bus.lsb_done;
        obs_data = bus.if_done ? bus.if_data : bus.lsb_rdata;
        bus.if_req = 1'b0; bus.lsb_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0; bus.lsb_req = 1'b0;
    rdy_in = 1'b1; clear = 1'b0; rst_in = 1'b0; bus.io_buffer_full = 1'b0;
    tick();
  endtask

  function automatic int nbytes_of(input int kind, input logic [1:0] sz);
    if (kind == 0) return 4;
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r, ai;
    r = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      r[8*i +: 8] = shadow[ai[9:0]];
    end
    return r;
  endfunction

  task automatic test_reset();
    bus.if_req = 0; bus.if_addr = 0; bus.lsb_req = 0; bus.lsb_wr = 0; bus.lsb_addr = 0;
    bus.lsb_size = 0; bus.lsb_wdata = 0; bus.io_buffer_full = 0;
    rdy_in = 1'b1; clear = 1'b0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    vectors++;
    if ({bus.mem_a, bus.mem_wr, bus.mem_dout, bus.if_done, bus.lsb_done} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_bus: a=%h wr=%b dout=%h ifd=%b lsd=%b want all 0",
               bus.mem_a, bus.mem_wr, bus.mem_dout, bus.if_done, bus.lsb_done);
    end
    vectors++;
    if (bus.if_data !== 32'd0 || bus.lsb_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: if_data=%h lsb_rdata=%h want 0", bus.if_data, bus.lsb_rdata);
    end
    for (int i = 0; i < 1024; i++) poke(32'(i), 8'($urandom));
  endtask

  task automatic test_if_read();
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h00); poke(32'h1002, 8'h50); poke(32'h1003, 8'h00);
    knobs_clear();
    xact(0, 32'h1000, 2'd0, 32'd0, 12);
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (tr_a[c] !== 32'h1000 + 32'(c-1) || tr_wr[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL if_read_bus c%0d: a=%h wr=%b want a=%h wr=0", c, tr_a[c], tr_wr[c], 32'h1000 + 32'(c-1));
      end
    end
    vectors++;
    if (done_cyc !== 6 || obs_if !== 1'b1 || obs_data !== 32'h00500013) begin
      miscompares++;
      $display("FAIL if_read_done: cyc=%0d if=%b data=%h want cyc=6 if=1 data=00500013", done_cyc, obs_if, obs_data);
    end
  endtask

  task automatic test_store_half();
    knobs_clear();
    xact(2, 32'h20, 2'd1, 32'h0000BEEF, 12);
    vectors++;
    if (tr_a[1] !== 32'h20 || tr_d[1] !== 8'hEF || tr_wr[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL store_half_b0: a=%h d=%h wr=%b want 20/ef/1", tr_a[1], tr_d[1], tr_wr[1]);
    end
    vectors++;
    if (tr_a[2] !== 32'h21 || tr_d[2] !== 8'hBE || tr_wr[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL store_half_b1: a=%h d=%h wr=%b want 21/be/1", tr_a[2], tr_d[2], tr_wr[2]);
    end
    vectors++;
    if (done_cyc !== 3 || obs_lsb !== 1'b1) begin
      miscompares++;
      $display("FAIL store_half_done: cyc=%0d lsb=%b want 3/1", done_cyc, obs_lsb);
    end
    shadow[10'h20] = 8'hEF; shadow[10'h21] = 8'hBE;
    vectors++;
    if (ram[10'h20] !== 8'hEF || ram[10'h21] !== 8'hBE) begin
      miscompares++;
      $display("FAIL store_half_ram: %h %h want ef be", ram[10'h20], ram[10'h21]);
    end
  endtask

  task automatic test_priority();
    int lsb_c, if_c;
    logic [31:0] lsb_v, if_v, exp_if;
    poke(32'h100, 8'h80);
    knobs_clear(); rdy_in = 1'b1;
    exp_if = model_read(32'h0, 4);
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h100; bus.lsb_size = 2'd0;
    lsb_c = -1; if_c = -1; lsb_v = 32'd0; if_v = 32'd0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (bus.lsb_done && lsb_c < 0) begin lsb_c = c; lsb_v = bus.lsb_rdata; bus.lsb_req = 1'b0; end
      if (bus.if_done && if_c < 0) begin if_c = c; if_v = bus.if_data; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.lsb_req = 1'b0;
    vectors++;
    if (lsb_c !== 3 || lsb_v !== 32'h00000080) begin
      miscompares++;
      $display("FAIL prio_lsb: cyc=%0d data=%h want 3/00000080", lsb_c, lsb_v);
    end
    vectors++;
    if (if_c !== 10 || if_v !== exp_if) begin
      miscompares++;
      $display("FAIL prio_if: cyc=%0d data=%h want 10/%h", if_c, if_v, exp_if);
    end
  endtask

  task automatic test_io_stall();
    knobs_clear(); full_from = 0; full_to = 4;
    xact(2, 32'h30000, 2'd0, 32'h41, 16);
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (tr_wr[c] !== 1'b0 || tr_a[c] !== 32'd0) begin
        miscompares++;
        $display("FAIL io_stall_idle c%0d: wr=%b a=%h want 0/0", c, tr_wr[c], tr_a[c]);
      end
    end
    vectors++;
    if (tr_wr[6] !== 1'b1 || tr_d[6] !== 8'h41 || tr_a[6] !== 32'h30000 || done_cyc !== 7) begin
      miscompares++;
      $display("FAIL io_stall_write: wr=%b d=%h a=%h done=%0d want 1/41/30000/7", tr_wr[6], tr_d[6], tr_a[6], done_cyc);
    end
    shadow[0] = 8'h41;
  endtask

  task automatic test_clear();
    logic [31:0] prev, wd, ai;
    prev = bus.if_data;
    knobs_clear(); clr_at = 3;
    xact(0, 32'h200, 2'd0, 32'd0, 12);
    vectors++;
    if (done_cyc !== -1 || tr_a[4] !== 32'd0 || tr_wr[4] !== 1'b0 || bus.if_data !== prev) begin
      miscompares++;
      $display("FAIL clear_if: done=%0d a4=%h wr4=%b data=%h want -1/0/0/%h", done_cyc, tr_a[4], tr_wr[4], bus.if_data, prev);
    end
    // Flush in the final capture cycle of a byte load also kills the pulse.
    prev = bus.lsb_rdata;
    knobs_clear(); clr_at = 2;
    xact(1, 32'h155, 2'd0, 32'd0, 10);
    vectors++;
    if (done_cyc !== -1 || bus.lsb_rdata !== prev) begin
      miscompares++;
      $display("FAIL clear_ld_last: done=%0d data=%h want -1/%h", done_cyc, bus.lsb_rdata, prev);
    end
    wd = $urandom;
    knobs_clear(); clr_at = 2;
    xact(2, 32'h2F0, 2'd2, wd, 12);
    vectors++;
    if (done_cyc !== 5 || obs_lsb !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_st_done: cyc=%0d lsb=%b want 5/1", done_cyc, obs_lsb);
    end
    for (int i = 0; i < 4; i++) begin
      ai = 32'h2F0 + 32'(i);
      shadow[ai[9:0]] = wd[8*i +: 8];
      vectors++;
      if (ram[ai[9:0]] !== shadow[ai[9:0]]) begin
        miscompares++;
        $display("FAIL clear_st_ram b%0d: got %h want %h", i, ram[ai[9:0]], shadow[ai[9:0]]);
      end
    end
  endtask

  task automatic test_rdy();
    logic [31:0] a, exp;
    a = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 1020));
    exp = model_read(a, 4);
    knobs_clear(); frz_at = 3; frz_len = 3;
    xact(0, a, 2'd0, 32'd0, 16);
    vectors++;
    if (done_cyc !== 9 || obs_data !== exp) begin
      miscompares++;
      $display("FAIL rdy_freeze: cyc=%0d data=%h want 9/%h", done_cyc, obs_data, exp);
    end
    for (int c = 3; c <= 6; c++) begin
      vectors++;
      if (tr_a[c] !== a + 32'd2) begin
        miscompares++;
        $display("FAIL rdy_hold c%0d: a=%h want %h", c, tr_a[c], a + 32'd2);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    logic [7:0]  old2, old3;
    wd = $urandom;
    old2 = shadow[10'h42]; old3 = shadow[10'h43];
    knobs_clear(); rst_at = 2;
    xact(2, 32'h40, 2'd2, wd, 10);
    for (int c = 3; c <= 10; c++) begin
      vectors++;
      if (tr_a[c] !== 32'd0 || tr_wr[c] !== 1'b0 || tr_d[c] !== 8'd0) begin
        miscompares++;
        $display("FAIL rst_mid_bus c%0d: a=%h wr=%b d=%h want 0", c, tr_a[c], tr_wr[c], tr_d[c]);
      end
    end
    shadow[10'h40] = wd[7:0]; shadow[10'h41] = wd[15:8];
    vectors++;
    if (done_cyc !== -1 || bus.if_data !== 32'd0 || bus.lsb_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_out: done=%0d if=%h lsb=%h want -1/0/0", done_cyc, bus.if_data, bus.lsb_rdata);
    end
    vectors++;
    if (ram[10'h40] !== wd[7:0] || ram[10'h41] !== wd[15:8] || ram[10'h42] !== old2 || ram[10'h43] !== old3) begin
      miscompares++;
      $display("FAIL rst_mid_ram: %h %h %h %h want %h %h %h %h", ram[10'h40], ram[10'h41], ram[10'h42], ram[10'h43],
               wd[7:0], wd[15:8], old2, old3);
    end
  endtask

  // Random traffic, issued back to back at the earliest legal cycle.
  task automatic test_back_to_back();
    int kind, n, c, issued, exp_done;
    logic [31:0] a, wd, exp, ai;
    logic [1:0]  sz;
    bit          io;
    bit          iss [0:63];
    int          bidx [0:63];
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom);
      a = $urandom;
      if (t % 9 == 0) a = 32'hFFFF_FFFE;
      if (kind == 2 && $urandom_range(0, 1) == 1) a[17:16] = 2'b11;
      wd = $urandom;
      n = nbytes_of(kind, sz);
      knobs_clear();
      if (kind == 2) begin
        full_from = $urandom_range(0, 3);
        full_to = full_from + $urandom_range(0, 4) - 1;
      end
      if (kind != 2) begin
        exp = model_read(a, n);
        xact(kind, a, sz, wd, 20);
        vectors++;
        if (done_cyc !== n + 2 || obs_data !== exp || obs_if !== (kind == 0) || obs_lsb !== (kind == 1)) begin
          miscompares++;
          $display("FAIL rnd_rd t%0d k%0d a=%h n=%0d: cyc=%0d data=%h if=%b lsb=%b want cyc=%0d data=%h",
                   t, kind, a, n, done_cyc, obs_data, obs_if, obs_lsb, n + 2, exp);
        end
        for (int k = 1; k <= n + 1; k++) begin
          vectors++;
          if (tr_wr[k] !== 1'b0 || tr_a[k] !== ((k <= n) ? a + 32'(k-1) : 32'd0)) begin
            miscompares++;
            $display("FAIL rnd_rd_bus t%0d c%0d: a=%h wr=%b", t, k, tr_a[k], tr_wr[k]);
          end
        end
      end else begin
        io = (a[17:16] == 2'b11);
        for (int k = 0; k < 64; k++) begin iss[k] = 1'b0; bidx[k] = 0; end
        issued = 0; c = 0;
        while (issued < n) begin
          if (!(io && c >= full_from && c <= full_to)) begin
            iss[c] = 1'b1; bidx[c] = issued; issued++;
          end
          c++;
        end
        exp_done = c + 1;
        xact(2, a, sz, wd, 30);
        vectors++;
        if (done_cyc !== exp_done || obs_lsb !== 1'b1 || obs_if !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_st t%0d a=%h n=%0d stall=%0d..%0d: cyc=%0d want %0d",
                   t, a, n, full_from, full_to, done_cyc, exp_done);
        end
        for (int k = 1; k < exp_done; k++) begin
          vectors++;
          if (tr_wr[k] !== iss[k-1] ||
              tr_a[k] !== (iss[k-1] ? a + 32'(bidx[k-1]) : 32'd0) ||
              tr_d[k] !== (iss[k-1] ? wd[8*bidx[k-1] +: 8] : 8'd0)) begin
            miscompares++;
            $display("FAIL rnd_st_bus t%0d c%0d: a=%h wr=%b d=%h want wr=%b", t, k, tr_a[k], tr_wr[k], tr_d[k], iss[k-1]);
          end
        end
        for (int i = 0; i < n; i++) begin
          ai = a + 32'(i);
          shadow[ai[9:0]] = wd[8*i +: 8];
          vectors++;
          if (ram[ai[9:0]] !== shadow[ai[9:0]]) begin
            miscompares++;
            $display("FAIL rnd_st_ram t%0d b%0d: got %h want %h", t, i, ram[ai[9:0]], shadow[ai[9:0]]);
          end
        end
      end
    end
  endtask

  initial begin
    knobs_clear();
    cur_kind = 0;
    test_reset();
    test_if_read();
    test_store_half();
    test_priority();
    test_io_stall();
    test_clear();
    test_rdy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
